serial_word_rx: RTL and testbench

Serial-to-parallel word receiver for the datapath: the receiving end of the serial link driven by the left-shifting (MSB-first) word transmitter. A per-frame bit counter and left-shifting accumulator rebuild a WIDTH-bit word from a qualified bit stream. The completed word is held in a one-word output buffer with a valid/ready handshake toward the datapath register file. Overrun is flagged rather than silently lost.

---
 rtl/serial_word_rx_if.sv | 26 ++
 rtl/serial_word_rx.sv | 141 ++++++++++++++
 tb/tb_serial_word_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_word_rx_if.sv
// Bundle of the serial receiver's stream inputs and output-buffer handshake.
// master drives the serial stream and consumes the word; slave is the receiver.
interface serial_word_rx_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sin;
  logic             sin_valid;
  logic             out_ready;
  logic             ovr_clr;
  logic [WIDTH-1:0] dout;
  logic             out_valid;
  logic             busy;
  logic             ovr;
  logic             par_err;

  modport master (
    output start, sin, sin_valid, out_ready, ovr_clr,
    input  dout, out_valid, busy, ovr, par_err
  );

  modport slave (
    input  start, sin, sin_valid, out_ready, ovr_clr,
    output dout, out_valid, busy, ovr, par_err
  );
endinterface

// File: rtl/serial_word_rx.sv
// MSB-first serial-to-parallel word receiver with a one-word output buffer,
// valid/ready handshake and sticky overrun. Optional trailing even parity: RX_PARITY_EN.
module serial_word_rx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              clr,
  serial_word_rx_if.slave  bus
);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               ovr_q, ovr_d;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   word;
  logic               complete;
  logic               load;

  // Without parity the accumulator's top bit is never needed: the final bit
  // completes the word straight from the shift path, so it keeps WIDTH-1 bits.
`ifdef RX_PARITY_EN
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               perr_q, perr_d;
  logic               perr_new;
  assign shifted = {sreg_q[WIDTH-2:0], bus.sin};
`else
  logic [WIDTH-2:0]   sreg_q, sreg_d;
  assign shifted = {sreg_q, bus.sin};
`endif

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    word     = shifted;
`ifdef RX_PARITY_EN
    perr_new = 1'b0;
`endif
    if (bus.start) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(WIDTH);
      sreg_d  = '0;
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (bus.sin_valid) begin
`ifdef RX_PARITY_EN
            sreg_d = shifted;
`else
            sreg_d = shifted[WIDTH-2:0];
`endif
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
`ifdef RX_PARITY_EN
              state_d = PAR;
`else
              state_d  = IDLE;
              complete = 1'b1;
`endif
            end
          end
        end
`ifdef RX_PARITY_EN
        PAR: begin
          if (bus.sin_valid) begin
            state_d  = IDLE;
            complete = 1'b1;
            word     = sreg_q;
            perr_new = ^{sreg_q, bus.sin};
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion may load in the same cycle the held word is consumed.
  always_comb begin
    load   = complete & (~vld_q | bus.out_ready);
    vld_d  = vld_q & ~bus.out_ready;
    dout_d = dout_q;
    ovr_d  = (complete & ~load) | (ovr_q & ~bus.ovr_clr);
`ifdef RX_PARITY_EN
    perr_d = perr_q;
`endif
    if (load) begin
      vld_d  = 1'b1;
      dout_d = word;
`ifdef RX_PARITY_EN
      perr_d = perr_new;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
`ifdef RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ovr       = ovr_q;
`ifdef RX_PARITY_EN
  assign bus.par_err   = perr_q;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: frames, gaps, overrun, restart, reset, parity.
module tb_serial_word_rx;
  logic clk = 1'b0;
  logic clr;
  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  serial_word_rx_if #(.WIDTH(32)) bus ();

  serial_word_rx #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Start pulse then every sample of one frame; the final qualified sample
  // carries last_rdy/last_oclr. pflip inverts the (even) parity bit.
  task automatic frame(input logic [31:0] w, input bit gaps, input bit last_rdy,
                       input bit last_oclr, input bit pflip, input bit chk_pre);
    int nb;
    logic b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
`ifdef RX_PARITY_EN
    nb = 33;
`else
    nb = 32;
`endif
    for (int k = 0; k < nb; k++) begin
      b = (k < 32) ? w[31-k] : ((^w) ^ pflip);
      if (gaps) begin
        bus.sin_valid = 1'b0;
        bus.sin       = ~b;
        tick();
      end
      if (k == nb - 1) begin
        if (chk_pre) begin
          check("pre_last_valid", {31'd0, bus.out_valid}, 32'd0);
          check("pre_last_busy", {31'd0, bus.busy}, 32'd1);
        end
        bus.out_ready = last_rdy;
        bus.ovr_clr   = last_oclr;
      end
      bus.sin       = b;
      bus.sin_valid = 1'b1;
      tick();
    end
    bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovr_clr   = 1'b0;
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.sin = 1'b0; bus.sin_valid = 1'b0;
    bus.out_ready = 1'b0; bus.ovr_clr = 1'b0;
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    check("rst_dout", bus.dout, 32'h0);
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ovr", {31'd0, bus.ovr}, 32'd0);
    check("rst_perr", {31'd0, bus.par_err}, 32'd0);

    // continuous frame, consumer idle
    frame(32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("f1_dout", bus.dout, 32'hA5A5_0F0F);
    check("f1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("f1_busy", {31'd0, bus.busy}, 32'd0);
    check("f1_ovr", {31'd0, bus.ovr}, 32'd0);
    check("f1_perr", {31'd0, bus.par_err}, 32'd0);
    consume();
    check("f1_drained", {31'd0, bus.out_valid}, 32'd0);
    check("f1_hold_dout", bus.dout, 32'hA5A5_0F0F);

    // same word with gaps between qualified bits
    frame(32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("gap_dout", bus.dout, 32'hA5A5_0F0F);
    check("gap_valid", {31'd0, bus.out_valid}, 32'd1);

    // overrun while buffer is held
    frame(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_set", {31'd0, bus.ovr}, 32'd1);
    check("ovr_dout", bus.dout, 32'hA5A5_0F0F);
    check("ovr_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("ovr_clr", {31'd0, bus.ovr}, 32'd0);

    // consume on the completion cycle: new word loads, no overrun
    frame(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("same_cyc_dout", bus.dout, 32'hDEAD_BEEF);
    check("same_cyc_valid", {31'd0, bus.out_valid}, 32'd1);
    check("same_cyc_ovr", {31'd0, bus.ovr}, 32'd0);
    consume();
    check("dbe_drained", {31'd0, bus.out_valid}, 32'd0);

    // restart after 10 bits; restart start coincides with a qualified bit
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.sin = 1'b1; bus.sin_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    frame(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_dout", bus.dout, 32'h0000_FFFF);
    check("restart_valid", {31'd0, bus.out_valid}, 32'd1);
    check("restart_ovr", {31'd0, bus.ovr}, 32'd0);

    // overrun set wins over simultaneous ovr_clr
    frame(32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("set_vs_clr_ovr", {31'd0, bus.ovr}, 32'd1);
    check("set_vs_clr_dout", bus.dout, 32'h0000_FFFF);

    // reset mid-frame discards everything
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.sin = 1'b1; bus.sin_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("midclr_dout", bus.dout, 32'h0);
    check("midclr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midclr_busy", {31'd0, bus.busy}, 32'd0);
    check("midclr_ovr", {31'd0, bus.ovr}, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    bus.sin_valid = 1'b0;
    check("idle_ignore_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle_ignore_busy", {31'd0, bus.busy}, 32'd0);

    // bit presented during the start cycle is not accepted
    bus.sin = 1'b1; bus.sin_valid = 1'b1;
    frame(32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("startbit_dout", bus.dout, 32'h8000_0001);
    consume();

`ifdef RX_PARITY_EN
    frame(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("par_ok_dout", bus.dout, 32'h0000_0001);
    check("par_ok_err", {31'd0, bus.par_err}, 32'd0);
    consume();
    frame(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("par_bad_dout", bus.dout, 32'h0000_0001);
    check("par_bad_err", {31'd0, bus.par_err}, 32'd1);
    check("par_bad_valid", {31'd0, bus.out_valid}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
